// File: rtl/div_pkg.sv
// Shared constants and the result-entry layout for the divider result buffer.
package div_pkg;

    localparam int N_DEFAULT = 5;
    localparam int M_DEFAULT = 3;
    localparam int Q_W       = N_DEFAULT - M_DEFAULT + 1;
    localparam int R_W       = M_DEFAULT;

    typedef struct packed {
        logic [Q_W-1:0] quotient;
        logic [R_W-1:0] remainder;
        logic           div_zero;
    } div_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/div_result_fifo.sv
// Result FIFO storage and pointers; head data reads as zero when empty.
module div_result_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= wr_data;
    end

    // DEPTH is a power of two, so the natural pointer rollover is the modulo wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);
    assign count   = count_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/div_result_buffer.sv
// Divider result buffer: FIFO, credit/inflight tracking and sticky error.
// Optional per-entry divide-by-zero flag enabled by DIV_RESULT_ZERO_FLAG_EN.
module div_result_buffer
    import div_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int M     = M_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue,
    output logic                     credit_ok,
    input  logic                     cell_rdy,
    input  logic [N-M:0]             cell_merchant,
    input  logic [M-1:0]             cell_remainder,
    input  logic [M-1:0]             cell_divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-M:0]             out_quotient,
    output logic [M-1:0]             out_remainder,
    output logic                     out_div_zero,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow_err
);

    localparam int QW = N - M + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);
`ifdef DIV_RESULT_ZERO_FLAG_EN
    localparam int EW = QW + M + 1;
`else
    localparam int EW = QW + M;
`endif

    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          drop;
    logic [CW-1:0] occ_next;
    logic [CW-1:0] inflight_reg;
    logic [CW-1:0] inflight_next;
    logic [CW:0]   credit_sum;
    logic          credit_ok_reg;
    logic          overflow_err_reg;

`ifdef DIV_RESULT_ZERO_FLAG_EN
    assign wr_data      = {cell_merchant, cell_remainder, (cell_divisor == '0)};
    assign out_div_zero = rd_data[0];
`else
    logic unused_divisor;
    assign unused_divisor = ^cell_divisor;
    assign wr_data        = {cell_merchant, cell_remainder};
    assign out_div_zero   = 1'b0;
`endif

    assign rd_en = ~empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign wr_en = cell_rdy & (~full | rd_en);
    assign drop  = cell_rdy & full & ~rd_en;

    div_result_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid     = ~empty;
    assign out_quotient  = rd_data[EW-1 -: QW];
    assign out_remainder = rd_data[EW-QW-1 -: M];
    assign occupancy     = count;

    always_comb begin
        inflight_next = inflight_reg;
        if (issue && !cell_rdy && inflight_reg != DEPTH_C)
            inflight_next = inflight_reg + 1'b1;
        else if (!issue && cell_rdy && inflight_reg != '0)
            inflight_next = inflight_reg - 1'b1;
    end

    assign occ_next   = count + CW'(wr_en) - CW'(rd_en);
    assign credit_sum = {1'b0, occ_next} + {1'b0, inflight_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_reg     <= '0;
            credit_ok_reg    <= 1'b1;
            overflow_err_reg <= 1'b0;
        end else begin
            inflight_reg  <= inflight_next;
            credit_ok_reg <= (credit_sum < DEPTH_S);
            if (drop || (issue && !credit_ok_reg) || (cell_rdy && inflight_reg == '0))
                overflow_err_reg <= 1'b1;
        end
    end

    assign credit_ok    = credit_ok_reg;
    assign overflow_err = overflow_err_reg;

endmodule
